// File: rtl/frame_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_scheduler_if
// Description : Stage request/acknowledge bundle between the frame update
//               scheduler and the paddle, ball and brick update engines.
//                 req_paddle/req_ball/req_brick : scheduler -> engines, level,
//                                                 high while a stage is pending
//                 ack_paddle/ack_ball/ack_brick : engines -> scheduler,
//                                                 one-cycle completion pulses
//               Modports: master = scheduler side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_update_scheduler_if;
    logic req_paddle;
    logic req_ball;
    logic req_brick;
    logic ack_paddle;
    logic ack_ball;
    logic ack_brick;

    modport master (
        output req_paddle, req_ball, req_brick,
        input  ack_paddle, ack_ball, ack_brick
    );

    modport slave (
        input  req_paddle, req_ball, req_brick,
        output ack_paddle, ack_ball, ack_brick
    );
endinterface
`default_nettype wire

// File: rtl/frame_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_scheduler
// Description : Runs the once-per-frame game-state update sequence
//               (paddle -> ball -> brick) inside vertical blanking. A
//               sequence starts when the pixel tick lands on (x=0, y=V_ACTIVE)
//               and is aborted, with a sticky overrun flag, if active video
//               restarts (x=0, y=0) before it completes.
//               Optional build macro: STAGE_WATCHDOG_EN adds a per-stage
//               ack watchdog that skips a stalled stage after STAGE_TIMEOUT
//               clocks and records it in stage_timeout.
// Ports       : clock, reset          - clock, async active-high reset
//               pTick, pixelX, pixelY - pixel enable and coordinates from sync
//               pause                 - suppress the sequence of this frame
//               clear_overrun         - synchronous clear of overrun
//               stage_bus (master)    - req/ack handshakes to the engines
//               frame_tick            - pulse at vertical-blank start
//               update_busy           - a stage request is pending
//               update_done           - pulse when a sequence completes
//               overrun               - sticky: sequence cut off by video
//               frame_count           - completed sequences, wraps at 16 bits
//               stage_timeout         - sticky {brick, ball, paddle} timeouts
// Revision    : 1.0 - initial release
// ============================================================================
module frame_update_scheduler #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int STAGE_TIMEOUT = 1023
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic                 pTick,
    input  wire logic [9:0]           pixelX,
    input  wire logic [9:0]           pixelY,
    input  wire logic                 pause,
    input  wire logic                 clear_overrun,
    frame_update_scheduler_if.master  stage_bus,
    output logic                      frame_tick,
    output logic                      update_busy,
    output logic                      update_done,
    output logic                      overrun,
    output logic [15:0]               frame_count,
    output logic [2:0]                stage_timeout
);

    // Geometry and timeout must fit the 10-bit coordinate / counter width.
    if (H_ACTIVE < 1 || H_ACTIVE > 1023 || V_ACTIVE < 1 || V_ACTIVE > 1023 ||
        STAGE_TIMEOUT < 1 || STAGE_TIMEOUT > 1023) begin : g_bad_params
        $error("frame_update_scheduler: parameter out of 10-bit range");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PADDLE = 3'd1,
        BALL   = 3'd2,
        BRICK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic frame_start;      // vertical blank begins this cycle
    logic video_start;      // active video begins this cycle
    logic in_stage;
    logic abort;
    logic stage_ack;
    logic stage_expire;
    logic tick_next;

    assign frame_start = pTick && (pixelX == 10'd0) && (pixelY == 10'(V_ACTIVE));
    assign video_start = pTick && (pixelX == 10'd0) && (pixelY == 10'd0);

    assign in_stage = (state == PADDLE) || (state == BALL) || (state == BRICK);

    // A trigger arriving mid-sequence is illegal timing; it is handled exactly
    // like the start of active video so the frame is abandoned, not restarted.
    assign abort = in_stage && (video_start || frame_start);

    // Only the ack belonging to the current stage counts.
    always_comb begin
        stage_ack = 1'b0;
        case (state)
            PADDLE:  stage_ack = stage_bus.ack_paddle;
            BALL:    stage_ack = stage_bus.ack_ball;
            BRICK:   stage_ack = stage_bus.ack_brick;
            default: stage_ack = 1'b0;
        endcase
    end

`ifdef STAGE_WATCHDOG_EN
    logic [9:0] wd_count;
    logic [2:0] timeout_flags;

    // wd_count is 0 in the first cycle of a stage, so the request stays high
    // for exactly STAGE_TIMEOUT cycles before being skipped.
    assign stage_expire = in_stage && !stage_ack &&
                          (wd_count == 10'(STAGE_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_count      <= 10'd0;
            timeout_flags <= 3'b000;
        end else begin
            if (state_next != state) begin
                wd_count <= 10'd0;
            end else if (in_stage) begin
                wd_count <= wd_count + 10'd1;
            end

            if (stage_expire) begin
                case (state)
                    PADDLE:  timeout_flags[0] <= 1'b1;
                    BALL:    timeout_flags[1] <= 1'b1;
                    BRICK:   timeout_flags[2] <= 1'b1;
                    default: timeout_flags    <= timeout_flags;
                endcase
            end
        end
    end

    assign stage_timeout = timeout_flags;
`else
    assign stage_expire  = 1'b0;
    assign stage_timeout = 3'b000;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tick_next  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    tick_next = 1'b1;
                    if (!pause) begin
                        state_next = PADDLE;
                    end
                end
            end
            PADDLE:  if (stage_ack || stage_expire) state_next = BALL;
            BALL:    if (stage_ack || stage_expire) state_next = BRICK;
            BRICK:   if (stage_ack || stage_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Stage outputs are loaded from the next
    // state so they line up with the state register cycle for cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            frame_tick           <= 1'b0;
            stage_bus.req_paddle <= 1'b0;
            stage_bus.req_ball   <= 1'b0;
            stage_bus.req_brick  <= 1'b0;
            update_busy          <= 1'b0;
            update_done          <= 1'b0;
            overrun              <= 1'b0;
            frame_count          <= 16'd0;
        end else begin
            state                <= state_next;
            frame_tick           <= tick_next;
            stage_bus.req_paddle <= (state_next == PADDLE);
            stage_bus.req_ball   <= (state_next == BALL);
            stage_bus.req_brick  <= (state_next == BRICK);
            update_busy          <= (state_next == PADDLE) || (state_next == BALL) ||
                                    (state_next == BRICK);
            update_done          <= (state_next == DONE);

            if (state == DONE) begin
                frame_count <= frame_count + 16'd1;
            end

            // Setting has priority over a simultaneous clear.
            if (abort) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_update_scheduler
// Description : Self-checking bench for frame_update_scheduler. Engine models
//               ack each request in its third cycle unless disabled; expected
//               request lengths and frame counts are queued when a sequence
//               is launched and compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_update_scheduler;

    localparam int V_ACT = 480;
`ifdef STAGE_WATCHDOG_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pTick = 1'b0;
    logic [9:0]  pixelX = 10'd1;
    logic [9:0]  pixelY = 10'd0;
    logic        pause = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        frame_tick;
    logic        update_busy;
    logic        update_done;
    logic        overrun;
    logic [15:0] frame_count;
    logic [2:0]  stage_timeout;

    frame_update_scheduler_if bus ();

    frame_update_scheduler #(
        .H_ACTIVE      (640),
        .V_ACTIVE      (V_ACT),
        .STAGE_TIMEOUT (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pTick         (pTick),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .pause         (pause),
        .clear_overrun (clear_overrun),
        .stage_bus     (bus),
        .frame_tick    (frame_tick),
        .update_busy   (update_busy),
        .update_done   (update_done),
        .overrun       (overrun),
        .frame_count   (frame_count),
        .stage_timeout (stage_timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int stage;
        int len;
    } req_exp_t;

    req_exp_t    req_q[$];
    logic [15:0] fc_q[$];
    logic [15:0] exp_fc = 16'd0;
    int          exp_ticks = 0;
    int          seen_ticks = 0;

    task automatic push_req(input int s, input int l);
        req_exp_t e;
        e.stage = s;
        e.len   = l;
        req_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Engine models
    // ------------------------------------------------------------------
    bit en_paddle = 1'b1;
    bit en_ball   = 1'b1;
    bit en_brick  = 1'b1;
    bit stray_brick = 1'b0;
    int cnt_p = 0, cnt_b = 0, cnt_k = 0;

    always @(posedge clock) begin
        #2;
        if (reset) begin
            cnt_p = 0; cnt_b = 0; cnt_k = 0;
            bus.ack_paddle = 1'b0;
            bus.ack_ball   = 1'b0;
            bus.ack_brick  = 1'b0;
        end else begin
            cnt_p = bus.req_paddle ? cnt_p + 1 : 0;
            cnt_b = bus.req_ball   ? cnt_b + 1 : 0;
            cnt_k = bus.req_brick  ? cnt_k + 1 : 0;
            bus.ack_paddle = en_paddle && bus.req_paddle && (cnt_p == 3);
            bus.ack_ball   = en_ball   && bus.req_ball   && (cnt_b == 3);
            bus.ack_brick  = (en_brick && bus.req_brick && (cnt_k == 3)) || stray_brick;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: request run lengths and frame count after each update_done
    // ------------------------------------------------------------------
    int len_m[3] = '{0, 0, 0};
    bit fc_pending = 1'b0;

    always @(negedge clock) begin
        logic [2:0] reqv;
        req_exp_t   e;
        logic [15:0] f;
        if (reset) begin
            len_m      = '{0, 0, 0};
            fc_pending = 1'b0;
        end else begin
            reqv = {bus.req_brick, bus.req_ball, bus.req_paddle};
            for (int i = 0; i < 3; i++) begin
                if (reqv[i]) begin
                    len_m[i]++;
                end else if (len_m[i] > 0) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", i, 32'hFF);
                    end else begin
                        e = req_q.pop_front();
                        check("req_stage", i, e.stage);
                        check("req_len", len_m[i], e.len);
                    end
                    len_m[i] = 0;
                end
            end
            if (fc_pending) begin
                f = fc_q.pop_front();
                check("frame_count", {16'd0, frame_count}, {16'd0, f});
                fc_pending = 1'b0;
            end
            if (update_done) begin
                if (fc_q.size() == 0) check("done_unexpected", 1, 0);
                else fc_pending = 1'b1;
            end
            if (frame_tick) seen_ticks++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y);
        @(posedge clock); #1;
        pTick  = 1'b1;
        pixelX = x;
        pixelY = y;
        @(posedge clock); #1;
        pTick  = 1'b0;
        pixelX = x + 10'd1;
    endtask

    task automatic wait_drained(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clock); #1;
            if (req_q.size() == 0 && fc_q.size() == 0) break;
        end
        check("drain", req_q.size() + fc_q.size(), 0);
    endtask

    task automatic run_seq(input int ball_len, input bit stray);
        push_req(0, 3);
        push_req(1, ball_len);
        push_req(2, 3);
        exp_fc = exp_fc + 16'd1;
        fc_q.push_back(exp_fc);
        exp_ticks++;
        drive_pixel(10'd0, 10'(V_ACT));
        if (stray) stray_brick = 1'b1;
        @(negedge clock);
        check("frame_tick", frame_tick, 1);
        check("busy_paddle", update_busy, 1);
        check("req_paddle", bus.req_paddle, 1);
        @(posedge clock); #1;
        stray_brick = 1'b0;
        @(negedge clock);
        check("frame_tick_pulse", frame_tick, 0);
        wait_drained(2 * TMO + 100);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int seen;

        // Reset state
        @(negedge clock);
        check("rst_reqs", {bus.req_brick, bus.req_ball, bus.req_paddle}, 0);
        check("rst_flags", {frame_tick, update_busy, update_done, overrun}, 0);
        check("rst_fc", frame_count, 0);
        check("rst_timeout", stage_timeout, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Normal sequence
        run_seq(3, 1'b0);
        check("normal_overrun", overrun, 0);
        check("normal_fc", frame_count, 1);

        // Pause
        pause = 1'b1;
        exp_ticks++;
        drive_pixel(10'd0, 10'(V_ACT));
        @(negedge clock);
        check("pause_tick", frame_tick, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.req_paddle || bus.req_ball || bus.req_brick || update_busy) seen++;
            @(negedge clock);
        end
        check("pause_activity", seen, 0);
        check("pause_fc", frame_count, exp_fc);
        pause = 1'b0;

        // Overrun: ball ack withheld until active video restarts
        push_req(0, 3);
        push_req(1, 5);
        en_ball = 1'b0;
        exp_ticks++;
        drive_pixel(10'd0, 10'(V_ACT));
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.req_ball) break;
        end
        check("ovr_ball_rise", bus.req_ball, 1);
        repeat (4) @(posedge clock);
        #1;
        pTick = 1'b1; pixelX = 10'd0; pixelY = 10'd0;
        @(posedge clock); #1;
        pTick = 1'b0; pixelX = 10'd1;
        @(negedge clock);
        check("ovr_ball_drop", bus.req_ball, 0);
        check("ovr_flag", overrun, 1);
        check("ovr_busy", update_busy, 0);
        en_ball = 1'b1;
        wait_drained(20);
        check("ovr_fc", frame_count, exp_fc);
        run_seq(3, 1'b0);
        check("ovr_sticky", overrun, 1);

        // clear_overrun
        @(posedge clock); #1;
        clear_overrun = 1'b1;
        @(posedge clock); #1;
        clear_overrun = 1'b0;
        @(negedge clock);
        check("clear_overrun", overrun, 0);

        // Reset during BALL
        push_req(0, 3);
        exp_ticks++;
        drive_pixel(10'd0, 10'(V_ACT));
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.req_ball) break;
        end
        check("rst_ball_rise", bus.req_ball, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_reqs", {bus.req_brick, bus.req_ball, bus.req_paddle}, 0);
        check("rst_mid_flags", {update_busy, overrun, frame_tick}, 0);
        check("rst_mid_fc", frame_count, 0);
        req_q.delete();
        fc_q.delete();
        exp_fc = 16'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        run_seq(3, 1'b0);
        check("post_rst_fc", frame_count, 1);

        // Wrap plus stray ack_brick during the paddle stage
        @(posedge clock); #1;
        force dut.frame_count = 16'hFFFF;
        @(posedge clock); #1;
        release dut.frame_count;
        exp_fc = 16'hFFFF;
        run_seq(3, 1'b1);
        check("wrap_fc", frame_count, 0);

`ifdef STAGE_WATCHDOG_EN
        // Watchdog skips the stalled ball stage
        en_ball = 1'b0;
        run_seq(TMO, 1'b0);
        check("wd_timeout", stage_timeout, 3'b010);
        en_ball = 1'b1;
`else
        check("no_wd_timeout", stage_timeout, 0);
`endif

        check("tick_count", seen_ticks, exp_ticks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
